// File: rtl/thunderbird_lamp_controller.sv
// Thunderbird tail-lamp sequencer: blink prescaler, left/right/hazard arbitration, three-step chase.
// Optional brake overlay is compiled in when THUNDERBIRD_BRAKE_EN is defined.
module thunderbird_lamp_controller #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic left_sw,
    input  logic right_sw,
    input  logic hazard_sw,
`ifdef THUNDERBIRD_BRAKE_EN
    input  logic brake,
`endif
    output logic la,
    output logic lb,
    output logic lc,
    output logic ra,
    output logic rb,
    output logic rc,
    output logic tick,
    output logic busy
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1   = 3'd1,
        L2   = 3'd2,
        L3   = 3'd3,
        R1   = 3'd4,
        R2   = 3'd5,
        R3   = 3'd6,
        HAZ  = 3'd7
    } state_t;

    logic [CNT_W-1:0] count_reg;
    state_t           state_reg;
    state_t           state_next;
    logic             haz_req;
    logic [2:0]       left_next;
    logic [2:0]       right_next;
    logic [2:0]       left_reg;
    logic [2:0]       right_reg;

    // Blink prescaler: tick is high for the last clock of each step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tick    = (count_reg == CNT_MAX);
    assign haz_req = hazard_sw | (left_sw & right_sw);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Switches are only looked at on tick edges; between ticks the state holds.
    always_comb begin
        state_next = state_reg;
        if (tick) begin
            unique case (state_reg)
                IDLE: begin
                    if (haz_req)       state_next = HAZ;
                    else if (left_sw)  state_next = L1;
                    else if (right_sw) state_next = R1;
                    else               state_next = IDLE;
                end
                L1: begin
                    if (haz_req)       state_next = HAZ;
                    else if (!left_sw) state_next = IDLE;
                    else               state_next = L2;
                end
                L2: begin
                    if (haz_req)       state_next = HAZ;
                    else if (!left_sw) state_next = IDLE;
                    else               state_next = L3;
                end
                R1: begin
                    if (haz_req)        state_next = HAZ;
                    else if (!right_sw) state_next = IDLE;
                    else                state_next = R2;
                end
                R2: begin
                    if (haz_req)        state_next = HAZ;
                    else if (!right_sw) state_next = IDLE;
                    else                state_next = R3;
                end
                // End of chase and hazard-on phase both fall back to dark.
                L3, R3, HAZ: state_next = IDLE;
                default:     state_next = IDLE;
            endcase
        end
    end

    // Lamp decode is taken from next-state so lamps move on the same edge as the state.
    always_comb begin
        left_next  = 3'b000;
        right_next = 3'b000;
        unique case (state_next)
            IDLE:    begin left_next = 3'b000; right_next = 3'b000; end
            L1:      begin left_next = 3'b001; right_next = 3'b000; end
            L2:      begin left_next = 3'b011; right_next = 3'b000; end
            L3:      begin left_next = 3'b111; right_next = 3'b000; end
            R1:      begin left_next = 3'b000; right_next = 3'b100; end
            R2:      begin left_next = 3'b000; right_next = 3'b110; end
            R3:      begin left_next = 3'b000; right_next = 3'b111; end
            HAZ:     begin left_next = 3'b111; right_next = 3'b111; end
            default: begin left_next = 3'b000; right_next = 3'b000; end
        endcase
`ifdef THUNDERBIRD_BRAKE_EN
        // Brake lights every lamp on a side that is not running a chase.
        if (brake) begin
            if (!(state_next inside {L1, L2, L3})) left_next  = 3'b111;
            if (!(state_next inside {R1, R2, R3})) right_next = 3'b111;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            left_reg  <= 3'b000;
            right_reg <= 3'b000;
        end else begin
            left_reg  <= left_next;
            right_reg <= right_next;
        end
    end

    assign {la, lb, lc} = left_reg;
    assign {ra, rb, rc} = right_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: doc/thunderbird_lamp_controller.md
Name: thunderbird_lamp_controller

Overview:
- Complete tail-lamp sequencer for the Thunderbird turn-signal datapath: three lamps per side, {la,lb,lc} left and {ra,rb,rc} right.
- Prescales the system clock to a blink tick and arbitrates left, right and hazard requests.
- Sequences the selected side through the three-step chase; all lamp outputs are registered.
- Sits between the raw (already debounced) switch inputs and the lamp drivers.

Parameters:
- TICK_DIV, 4, clocks per blink step; legal range is 2 and up; tick counter width is $clog2(TICK_DIV).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset; 0 clears all state
- left_sw  input  1  left turn request, level
- right_sw  input  1  right turn request, level
- hazard_sw  input  1  hazard request, level
- la, lb, lc  output  1 each  left lamps, registered; lc is the innermost lamp
- ra, rb, rc  output  1 each  right lamps, registered; ra is the innermost lamp
- tick  output  1  one-clock pulse marking a step boundary
- busy  output  1  1 whenever state is not IDLE

Behaviour:
- Reset (reset=0, asynchronous): tick counter=0, state=IDLE, all six lamps=0. Outputs hold these values while reset is low.
- Prescaler:
  - Counter increments every clk and wraps TICK_DIV-1 -> 0.
  - tick = (count==TICK_DIV-1), decoded combinationally from the counter.
  - First tick falls at the TICK_DIV-th rising edge after reset releases.
- State changes only on edges where tick=1.
- Lamps are registered from next-state and therefore change on the same edge as the state.
- States and lamp vectors {la,lb,lc}/{ra,rb,rc}:
  - IDLE 000/000
  - L1 001/000
  - L2 011/000
  - L3 111/000
  - R1 000/100
  - R2 000/110
  - R3 000/111
  - HAZ 111/111
- Request haz = hazard_sw | (left_sw & right_sw).
- Transitions on tick:
  - IDLE: haz -> HAZ; else left_sw -> L1; else right_sw -> R1; else stay IDLE.
  - L1/L2: haz -> HAZ (preempt); else !left_sw -> IDLE (abort); else advance to L2/L3.
  - L3 -> IDLE unconditionally. A held switch restarts the chase on the next tick, giving a one-step dark gap.
  - R1/R2/R3: mirror of the left side using right_sw.
  - HAZ -> IDLE unconditionally, so the hazard blinks all-on/all-off at the tick rate.
- Opposite-side request during a chase is ignored until that chase returns to IDLE.
- Switch changes between ticks have no effect; inputs are sampled only on tick edges.
- Reset asserted mid-sequence: lamps clear immediately (asynchronous) and the counter restarts from 0.
- busy = (state != IDLE); it is registered state, not a decode of the inputs.

Optional Feature:
- Macro: THUNDERBIRD_BRAKE_EN.
- Defined:
  - Adds input port brake (1 bit), placed after hazard_sw.
  - Brake sampled every clk, not only on tick; lamp registers reflect it one clk after it changes.
  - While brake=1, every lamp of a side that is not chasing is forced to 1.
  - IDLE with brake: 111/111 steady.
  - L1..L3 with brake: left side follows the chase; right side = 111.
  - R1..R3 with brake: mirror of the left case.
  - HAZ with brake: 111/111; IDLE phase of the hazard blink shows 111/111, so the blink is suppressed.
  - State machine and tick are unaffected by brake.
- Undefined: no brake port; lamps are exactly the state decode above.

Test Plan (TICK_DIV=4; edges counted after reset release):
- Left held from reset: edges 4/8/12/16/20 -> left lamps 001/011/111/000/001; right=000 throughout; busy=1 at edge 4.
- Left held, left_sw dropped at edge 6: edge 8 -> IDLE, left 000, busy=0; no further change while all switches are 0.
- Left held, right_sw raised at edge 5 while left stays high: edge 8 -> HAZ (111/111, left&right form haz); edge 12 -> 000/000; edge 16 -> HAZ.
- Right held, right_sw dropped at edge 5, left_sw raised at edge 9: R1 at edge 4; IDLE at edge 8; L1 (001/000) at edge 12. Also check left_sw raised while the right chase is still running is ignored until IDLE.
- reset driven low at edge 10 mid-chase: all lamps 0 and busy=0 without a clock edge; after release, first tick at the 4th edge.
- THUNDERBIRD_BRAKE_EN, left held, brake=1 from edge 2: edge 3 -> right 111; edge 4 -> L1 with right 111; brake=0 -> right 000 one clk later.
